rr_arbiter_6: RTL and testbench
===============================

// Module: rr_arbiter_6
// PURPOSE
//  Round-robin arbiter that shares one resource among 6 requesters.
//  Produces a 3-bit grant index (0..5) plus its one-hot decode (6 bits).
//  Enforces one dead cycle between grants (break-before-make), so no two
//  requesters ever drive the shared resource in the same cycle.
//  Caps grant tenure at MAX_HOLD cycles so that no requester can starve the others.
// PARAMETERS
//  N_REQ     6   number of requesters; fixed at 6 (index 6 and 7 are illegal)
//  IDX_W     3   width of the grant index
//  MAX_HOLD  16  maximum cycles a grant is held before it is forcibly released
//  HOLD_W    5   width of the hold counter; must be >= clog2(MAX_HOLD+1)
// PORTS
//  clk        in   1      single clock, all state updates on the rising edge
//  reset      in   1      synchronous, active-high reset
//  req        in   6      level request; bit i held high while requester i wants or uses the resource
//  gnt        out  6      one-hot grant; all-zero when no grant is active
//  gnt_idx    out  3      binary index of the granted requester; valid only when gnt_valid=1
//  gnt_valid  out  1      high while a grant is active
//  timeout    out  1      single-cycle pulse when a grant is forcibly ended at MAX_HOLD
// BEHAVIOUR
//  Reset (sampled at a rising edge):
//   state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
//   Reset in the middle of a grant: gnt drops at that edge; no timeout pulse.
//  States: IDLE, GRANT, RECOVER (all registered; every output is registered).
//  Pick function: first i with req[i]=1, scanning circularly ptr, ptr+1, ..., 5, 0, ...
//  IDLE:
//   any req -> GRANT; gnt_idx=pick, gnt=1<<pick, gnt_valid=1, hold_cnt=0.
//   Latency: req high before edge k gives gnt high after edge k (1 cycle).
//  GRANT:
//   hold_cnt increments every cycle.
//   Release when req[gnt_idx]=0 or hold_cnt=MAX_HOLD-1:
//    -> RECOVER; gnt=0, gnt_valid=0; ptr=(gnt_idx==5)?0:gnt_idx+1.
//   timeout=1 for that one cycle only when the release was forced (req still high).
//   Changes on other req bits during GRANT are ignored.
//  RECOVER:
//   exactly one cycle with gnt=0; arbitrates with the updated ptr.
//   any req -> GRANT (same as IDLE); else -> IDLE.
//   Back-to-back grants therefore have a 1-cycle gap.
//  Fairness: the previous holder has lowest priority in the next pick; a requester
//   that timed out is re-granted after RECOVER only if no other req is high.
//  Invariants: popcount(gnt)<=1; gnt==(1<<gnt_idx) when gnt_valid=1; gnt_idx<=5;
//   gnt_valid==|gnt; hold_cnt never exceeds MAX_HOLD-1.
// STRUCTURE
//  Shared package arb_pkg: state typedef (IDLE/GRANT/RECOVER), N_REQ, IDX_W.
//  Sub-module rr_pick_6: combinational circular priority picker,
//   in: req[5:0], ptr[2:0]; out: any, idx[2:0].
//  The one-hot grant is produced by a registered 3-to-6 decode of the next index.
// TESTING
//  1 reset with req=6'b111111 -> gnt=0, gnt_valid=0 during reset; first grant
//    after reset is idx 0.
//  2 req=6'b000100 held 3 cycles then dropped -> gnt=6'b000100, idx=2 for
//    3 cycles, then 1 dead cycle, then IDLE; ptr=3.
//  3 req=6'b111111 constant, each holder drops its req after 2 cycles and
//    re-raises it -> grant order 0,1,2,3,4,5,0 with a 1-cycle gap between grants.
//  4 req=6'b000001 held 40 cycles -> grant 16 cycles, timeout pulse, 1 gap cycle,
//    re-grant to idx 0; timeout never high while gnt_valid=1.
//  5 idx 5 granted, req=6'b100011, bit 5 drops -> next grant idx 0 (wrap), not 1.
//  6 reset asserted mid-grant (hold_cnt=7) -> outputs cleared at that edge,
//    timeout=0; after reset deasserts, arbitration restarts from ptr=0.
//  All runs: assertions on the invariants above and on the 1-cycle gap.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the six-way round-robin arbiter.
// Holds the FSM state encoding and a pointer-advance helper.
package arb_pkg;

  localparam int N_REQ = 6;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RECOVER
  } state_t;

  // Index following i, wrapping 5 back to 0.
  function automatic logic [IDX_W-1:0] next_ptr(
    input logic [IDX_W-1:0] i
  );
    return (i == IDX_W'(N_REQ-1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick_6.sv
// Circular priority picker: first set request at or after ptr.
// Purely combinational; out-of-range ptr is treated as 0.
module rr_pick_6
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   j;

  // Scan from the far end so the nearest requester to ptr wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    j    = '0;
    base = (ptr > IDX_W'(N_REQ-1)) ? '0 : ptr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j = {1'b0, base} + (IDX_W+1)'(k);
      if (j >= (IDX_W+1)'(N_REQ))
        j = j - (IDX_W+1)'(N_REQ);
      if (req[j[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_6.sv
// Six-way round-robin arbiter with break-before-make gap.
// Grant tenure is capped at MAX_HOLD cycles.
module rr_arbiter_6
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [IDX_W-1:0]  idx_n;
  logic              valid_n;
  logic              tout_n;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              release_now;

  rr_pick_6 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign release_now = !req[gnt_idx] ||
    (hold_cnt == HOLD_W'(MAX_HOLD-1));

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    idx_n   = gnt_idx;
    gnt_n   = gnt;
    valid_n = gnt_valid;
    tout_n  = 1'b0;
    unique case (state)
      IDLE, RECOVER: begin
        if (pick_any) begin
          state_n = GRANT;
          idx_n   = pick_idx;
          gnt_n   = N_REQ'(1) << pick_idx;
          valid_n = 1'b1;
          hold_n  = '0;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n = RECOVER;
          gnt_n   = '0;
          valid_n = 1'b0;
          ptr_n   = next_ptr(gnt_idx);
          tout_n  = req[gnt_idx];
          hold_n  = '0;
        end else begin
          hold_n  = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      timeout   <= tout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_6.sv
// Directed bench for rr_arbiter_6.
// Checks grants, gaps, timeout and invariants every cycle.
module tb_rr_arbiter_6;

  logic       clk;
  logic       reset;
  logic [5:0] req;
  logic [5:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_assert;
  int n_fail;
  logic       prev_v;
  logic [2:0] prev_i;

  rr_arbiter_6 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
        tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [5:0] dec;
    @(posedge clk);
    #1;
    chk("inv_onehot", 32'($countones(gnt) <= 1), 1);
    chk("inv_valid", 32'(gnt_valid), 32'(|gnt));
    chk("inv_idx", 32'(gnt_idx <= 3'd5), 1);
    chk("inv_tout", 32'(timeout && gnt_valid), 0);
    if (gnt_valid) begin
      dec = 6'd1 << gnt_idx;
      chk("inv_dec", 32'(gnt), 32'(dec));
    end
    if (prev_v && gnt_valid)
      chk("inv_gap", 32'(gnt_idx), 32'(prev_i));
    prev_v = gnt_valid;
    prev_i = gnt_idx;
  endtask

  task automatic expg(
    input string tag,
    input bit    v,
    input int    idx,
    input bit    t
  );
    logic [5:0] eg;
    eg = v ? (6'd1 << idx) : 6'd0;
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    if (v)
      chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, "_tout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    prev_v   = 1'b0;
    prev_i   = 3'd0;
    reset    = 1'b1;
    req      = 6'b111111;

    // 1: reset with all requests, then first grant is idx 0
    step(); expg("t1_rst0", 0, 0, 0);
    step(); expg("t1_rst1", 0, 0, 0);
    reset = 1'b0;
    step(); expg("t1_g0", 1, 0, 0);
    req = 6'b000000;
    step(); expg("t1_gap", 0, 0, 0);
    step(); expg("t1_idle", 0, 0, 0);

    // 2: single requester for 3 cycles, then ptr lands on 3
    req = 6'b000100;
    step(); expg("t2_c1", 1, 2, 0);
    step(); expg("t2_c2", 1, 2, 0);
    step(); expg("t2_c3", 1, 2, 0);
    req = 6'b000000;
    step(); expg("t2_gap", 0, 0, 0);
    step(); expg("t2_idle", 0, 0, 0);
    req = 6'b001001;
    step(); expg("t2_ptr3", 1, 3, 0);
    req = 6'b000000;
    step(); expg("t2_gap2", 0, 0, 0);
    step(); expg("t2_idle2", 0, 0, 0);

    // 3: rotation 0..5,0 with one dead cycle between grants
    reset = 1'b1;
    step(); expg("t3_rst", 0, 0, 0);
    reset = 1'b0;
    req = 6'b111111;
    for (int n = 0; n < 7; n++) begin
      step(); expg("t3_ga", 1, n % 6, 0);
      step(); expg("t3_gb", 1, n % 6, 0);
      req = 6'b111111 & ~(6'd1 << (n % 6));
      step(); expg("t3_gap", 0, 0, 0);
      req = (n == 6) ? 6'b000000 : 6'b111111;
    end
    step(); expg("t3_idle", 0, 0, 0);

    // 4: one requester held 40 cycles -> forced release
    req = 6'b000001;
    for (int s = 0; s < 40; s++) begin
      step();
      if ((s % 17) == 16)
        expg("t4_to", 0, 0, 1);
      else
        expg("t4_g", 1, 0, 0);
    end
    req = 6'b000000;
    step(); expg("t4_rel", 0, 0, 0);
    step(); expg("t4_idle", 0, 0, 0);

    // 5: wrap from idx 5 to idx 0
    req = 6'b100000;
    step(); expg("t5_g5", 1, 5, 0);
    req = 6'b100011;
    step(); expg("t5_hold", 1, 5, 0);
    req = 6'b000011;
    step(); expg("t5_gap", 0, 0, 0);
    step(); expg("t5_wrap", 1, 0, 0);
    req = 6'b000000;
    step(); expg("t5_rel", 0, 0, 0);
    step(); expg("t5_idle", 0, 0, 0);

    // 6: reset mid-grant at hold_cnt 7
    req = 6'b000100;
    step(); expg("t6_g", 1, 2, 0);
    for (int s = 0; s < 7; s++) begin
      step(); expg("t6_h", 1, 2, 0);
    end
    reset = 1'b1;
    step(); expg("t6_rst", 0, 0, 0);
    reset = 1'b0;
    req = 6'b111111;
    step(); expg("t6_g0", 1, 0, 0);
    req = 6'b000000;
    step(); expg("t6_rel", 0, 0, 0);
    step(); expg("t6_idle", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end

endmodule
